// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/MULH/DIVU/REMU unit beside the execute-stage ALU.
// It runs one shift-add or restoring step per cycle and stalls the pipeline through BusyE.
module muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StartE,
   input  logic [1:0]      OpE,
   input  logic [XLEN-1:0] SrcA_E,
   input  logic [XLEN-1:0] SrcB_E,
   input  logic            FlushE,
   output logic            BusyE,
   output logic            DoneE,
   output logic [XLEN-1:0] ResultE
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        op_r;
   logic [XLEN-1:0]   a_r;
   logic [XLEN-1:0]   b_r;
   // Multiply: full product. Divide: {partial remainder, dividend bits shifting into quotient}.
   logic [2*XLEN-1:0] acc_r;

   logic              accept_s;
   logic              div_zero_s;
   logic              last_s;
   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_sh_s;
   logic [XLEN:0]     div_diff_s;
   logic [2*XLEN-1:0] acc_next_s;
   logic [XLEN-1:0]   result_next_s;

   // Datapath step, result selection and the stall request
   always_comb begin
      accept_s      = (state_r == IDLE) && StartE && !FlushE;
      BusyE         = accept_s || (state_r == RUN);
      div_zero_s    = OpE[1] && (SrcB_E == {XLEN{1'b0}});
      last_s        = (cnt_r == CNT_W'(XLEN - 1));
      mul_sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (b_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
      div_sh_s      = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      // The shifted remainder is below 2*divisor, so the sign bit of this difference is the borrow.
      div_diff_s    = div_sh_s - {1'b0, b_r};
      acc_next_s    = acc_r;
      result_next_s = {XLEN{1'b0}};
      if (op_r[1]) begin
         if (div_diff_s[XLEN]) begin
            acc_next_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
         end else begin
            acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end
      case (op_r)
         2'b00:   result_next_s = acc_next_s[XLEN-1:0];
         2'b01:   result_next_s = acc_next_s[2*XLEN-1:XLEN];
         2'b10:   result_next_s = acc_next_s[XLEN-1:0];
         2'b11:   result_next_s = acc_next_s[2*XLEN-1:XLEN];
         default: result_next_s = acc_next_s[XLEN-1:0];
      endcase
   end

   // Sequencer state, operand capture, iteration and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         op_r    <= 2'b00;
         a_r     <= {XLEN{1'b0}};
         b_r     <= {XLEN{1'b0}};
         acc_r   <= {(2*XLEN){1'b0}};
         DoneE   <= 1'b0;
         ResultE <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               DoneE <= 1'b0;
               if (accept_s) begin
                  op_r  <= OpE;
                  a_r   <= SrcA_E;
                  b_r   <= SrcB_E;
                  cnt_r <= {CNT_W{1'b0}};
                  if (div_zero_s) begin
                     state_r <= DONE;
                     DoneE   <= 1'b1;
                     acc_r   <= {(2*XLEN){1'b0}};
                     ResultE <= OpE[0] ? SrcA_E : {XLEN{1'b1}};
                  end else begin
                     state_r <= RUN;
                     acc_r   <= OpE[1] ? {{XLEN{1'b0}}, SrcA_E} : {(2*XLEN){1'b0}};
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (FlushE) begin
                  state_r <= IDLE;
                  DoneE   <= 1'b0;
               end else begin
                  acc_r <= acc_next_s;
                  b_r   <= op_r[1] ? b_r : {1'b0, b_r[XLEN-1:1]};
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (last_s) begin
                     state_r <= DONE;
                     DoneE   <= 1'b1;
                     ResultE <= result_next_s;
                  end else begin
                     state_r <= RUN;
                     DoneE   <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               DoneE   <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               DoneE   <= 1'b0;
            end
         endcase
      end
   end

endmodule
